// File: rtl/lock_supervisor_if.sv
// lock_supervisor_if
// Groups the PLL-lock supervisor's level signals into one bundle.
//
// Signals:
//   locked      PLL lock flag (asynchronous to clk10), driven by master
//   rst_out     active-high reset for the 10 MHz domain, driven by slave
//   status_led  state-encoded LED drive, driven by slave
//   loss_count  saturating count of RUN->FAULT transitions, driven by slave
//   state       current supervisor FSM state (debug), driven by slave
//
// Handshake: there is no valid/ready pair here. Every signal is a plain
// level. locked may change at any time and is synchronised inside the
// slave. All slave outputs are registered and meaningful on every cycle,
// including while reset is asserted, when they hold their reset values.
//
// Modports:
//   master  lock source / observer (testbench or clocking wrapper)
//   slave   the supervisor itself
interface lock_supervisor_if #(
   parameter int LOSS_W = 8
);
   logic              locked;
   logic              rst_out;
   logic              status_led;
   logic [LOSS_W-1:0] loss_count;
   logic [1:0]        state;

   modport master (
      output locked,
      input  rst_out,
      input  status_led,
      input  loss_count,
      input  state
   );

   modport slave (
      input  locked,
      output rst_out,
      output status_led,
      output loss_count,
      output state
   );
endinterface

// File: rtl/lock_supervisor.sv
// lock_supervisor
// Synchronises the PLL locked flag, holds the 10 MHz domain in reset until
// lock has been stable for HOLD_CYCLES cycles, counts lock losses and drives
// a state-encoded status LED.
//
// Parameters:
//   HOLD_CYCLES  consecutive synchronised-locked cycles before release (>= 2)
//   LOSS_W       width of the saturating lock-loss counter
//   BLINK_BITS   width of the free-running LED blink counter (>= 5)
//
// Ports:
//   clk10  in   10 MHz clock, the only clock
//   rst    in   asynchronous active-high reset
//   bus    slave modport of lock_supervisor_if
//            locked in; rst_out, status_led, loss_count, state out
//
// Build option:
//   LOCK_SUP_STICKY_FAULT_EN  when defined, FAULT is terminal until rst;
//                             otherwise FAULT lasts 16 cycles and then
//                             returns to WAIT_LOCK.
module lock_supervisor #(
   parameter int HOLD_CYCLES = 1000,
   parameter int LOSS_W      = 8,
   parameter int BLINK_BITS  = 24
) (
   input logic              clk10,
   input logic              rst,
   lock_supervisor_if.slave bus
);
   localparam int                HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      HOLD      = 2'd1,
      RUN       = 2'd2,
      FAULT     = 2'd3
   } state_t;

   (* ASYNC_REG = "TRUE" *) logic locked_meta;
   (* ASYNC_REG = "TRUE" *) logic locked_s;

   state_t                state_q;
   logic                  rst_out_q;
   logic                  led_q;
   logic [HOLD_W-1:0]     hold_cnt;
   logic [LOSS_W-1:0]     loss_q;
   logic [BLINK_BITS-1:0] blink_cnt;
   logic [BLINK_BITS-1:0] blink_nxt;
   logic                  run_blink;
   logic                  fault_blink;
`ifndef LOCK_SUP_STICKY_FAULT_EN
   logic [3:0]            fault_cnt;
`endif

   // The LED flop is loaded from the blink value that blink_cnt takes on the
   // same edge, so status_led always matches the current state and counter.
   assign blink_nxt   = blink_cnt + BLINK_BITS'(1);
   assign run_blink   = blink_nxt[BLINK_BITS-1];
   assign fault_blink = blink_nxt[BLINK_BITS-5];

   always_ff @(posedge clk10 or posedge rst) begin
      if (rst) begin
         locked_meta <= 1'b0;
         locked_s    <= 1'b0;
      end else begin
         locked_meta <= bus.locked;
         locked_s    <= locked_meta;
      end
   end

   always_ff @(posedge clk10 or posedge rst) begin
      if (rst) begin
         blink_cnt <= '0;
      end else begin
         blink_cnt <= blink_nxt;
      end
   end

   always_ff @(posedge clk10 or posedge rst) begin
      if (rst) begin
         state_q   <= WAIT_LOCK;
         rst_out_q <= 1'b1;
         led_q     <= 1'b0;
         hold_cnt  <= '0;
         loss_q    <= '0;
`ifndef LOCK_SUP_STICKY_FAULT_EN
         fault_cnt <= '0;
`endif
      end else begin
         case (state_q)
            WAIT_LOCK: begin
               rst_out_q <= 1'b1;
               if (locked_s) begin
                  state_q  <= HOLD;
                  hold_cnt <= '0;
                  led_q    <= 1'b1;
               end else begin
                  led_q    <= 1'b0;
               end
            end
            HOLD: begin
               // A drop on any HOLD cycle, including the last, wins over
               // the release to RUN and is not counted as a loss.
               if (!locked_s) begin
                  state_q <= WAIT_LOCK;
                  led_q   <= 1'b0;
               end else if (hold_cnt == HOLD_LAST) begin
                  state_q   <= RUN;
                  rst_out_q <= 1'b0;
                  led_q     <= run_blink;
               end else begin
                  hold_cnt <= hold_cnt + HOLD_W'(1);
               end
            end
            RUN: begin
               if (!locked_s) begin
                  state_q   <= FAULT;
                  rst_out_q <= 1'b1;
                  led_q     <= fault_blink;
`ifndef LOCK_SUP_STICKY_FAULT_EN
                  fault_cnt <= '0;
`endif
                  if (loss_q != {LOSS_W{1'b1}}) begin
                     loss_q <= loss_q + LOSS_W'(1);
                  end
               end else begin
                  led_q <= run_blink;
               end
            end
            FAULT: begin
               rst_out_q <= 1'b1;
`ifdef LOCK_SUP_STICKY_FAULT_EN
               led_q <= fault_blink;
`else
               // Exit ignores locked_s: WAIT_LOCK re-qualifies lock anyway.
               if (fault_cnt == 4'd15) begin
                  state_q <= WAIT_LOCK;
                  led_q   <= 1'b0;
               end else begin
                  fault_cnt <= fault_cnt + 4'd1;
                  led_q     <= fault_blink;
               end
`endif
            end
            default: begin
               state_q   <= WAIT_LOCK;
               rst_out_q <= 1'b1;
               led_q     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rst_out    = rst_out_q;
   assign bus.status_led = led_q;
   assign bus.loss_count = loss_q;
   assign bus.state      = state_q;
endmodule

// File: tb/tb_lock_supervisor.sv
// tb_lock_supervisor
// Self-checking bench for lock_supervisor with HOLD_CYCLES = 8, LOSS_W = 8,
// BLINK_BITS = 6. A timestamp-based reference model predicts every output
// on every cycle; a vector table and hand-written sequences add targeted
// checks for the lock/hold/fault timing, saturation and async reset.
// Build option LOCK_SUP_STICKY_FAULT_EN selects the terminal-FAULT variant.
module tb_lock_supervisor;
   localparam int HOLD     = 8;
   localparam int LOSS     = 8;
   localparam int BLINK    = 6;
   localparam int LOSS_MAX = (1 << LOSS) - 1;
`ifdef LOCK_SUP_STICKY_FAULT_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk10 = 1'b0;
   logic rst;
   always #50 clk10 = ~clk10;

   lock_supervisor_if #(.LOSS_W(LOSS)) bus ();

   lock_supervisor #(
      .HOLD_CYCLES(HOLD),
      .LOSS_W     (LOSS),
      .BLINK_BITS (BLINK)
   ) dut (
      .clk10(clk10),
      .rst  (rst),
      .bus  (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Works in absolute cycle numbers since reset: locked_s is the locked
   // sample from two edges earlier; HOLD and FAULT end a fixed number of
   // cycles after their entry timestamp.
   int   m_c;
   int   m_entry;
   int   m_loss;
   int   m_st;
   logic m_ls;
   logic m_hist[$];

   always @(posedge clk10 or posedge rst) begin
      if (rst) begin
         m_c     = 0;
         m_entry = 0;
         m_loss  = 0;
         m_st    = 0;
         m_hist  = '{1'b0, 1'b0};
      end else begin
         m_ls = m_hist[1];
         m_hist.push_front(bus.locked);
         void'(m_hist.pop_back());
         m_c++;
         case (m_st)
            0: if (m_ls) begin m_st = 1; m_entry = m_c; end
            1: begin
               if (!m_ls) m_st = 0;
               else if (m_c - m_entry == HOLD) m_st = 2;
            end
            2: if (!m_ls) begin
               m_st = 3;
               m_entry = m_c;
               if (m_loss < LOSS_MAX) m_loss++;
            end
            default: if (!STICKY && (m_c - m_entry == 16)) m_st = 0;
         endcase
      end
   end

   function automatic int exp_led(input int st, input int c);
      case (st)
         0:       return 0;
         1:       return 1;
         2:       return (c >> (BLINK - 1)) & 1;
         default: return (c >> (BLINK - 5)) & 1;
      endcase
   endfunction

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk10) begin
      if (rst === 1'b0) begin
         check("mon_state",   int'(bus.state),      m_st);
         check("mon_rst_out", int'(bus.rst_out),    (m_st == 2) ? 0 : 1);
         check("mon_led",     int'(bus.status_led), exp_led(m_st, m_c));
         check("mon_loss",    int'(bus.loss_count), m_loss);
      end
   end

   // ---------------- driver tasks ----------------
   // Called at a negedge; returns at the negedge after n sampling edges.
   task automatic drive(input logic lk, input int n);
      bus.locked = lk;
      repeat (n) @(posedge clk10);
      @(negedge clk10);
   endtask

   task automatic wait_state(input logic [1:0] s, input int budget, input string name);
      int k;
      k = 0;
      while (bus.state !== s && k < budget) begin
         @(posedge clk10);
         @(negedge clk10);
         k++;
      end
      check(name, int'(bus.state), int'(s));
   endtask

   // Called at a negedge: asserts rst between edges and checks that the
   // outputs change before any clock edge arrives.
   task automatic async_reset_check(input string tag);
      #20;
      rst = 1'b1;
      #1;
      check({tag, "_state"},   int'(bus.state),      0);
      check({tag, "_rst_out"}, int'(bus.rst_out),    1);
      check({tag, "_led"},     int'(bus.status_led), 0);
      check({tag, "_loss"},    int'(bus.loss_count), 0);
      @(negedge clk10);
      rst = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic       lk;
      int         cyc;
      logic [1:0] st;
      logic       ro;
      int         loss;
   } vec_t;

   localparam int NV = 21;
   vec_t tbl[NV];

   // ---------------- main sequence ----------------
   initial begin
      bus.locked = 1'b0;
      rst        = 1'b1;
      #10;
      check("rst_state",   int'(bus.state),      0);
      check("rst_rst_out", int'(bus.rst_out),    1);
      check("rst_led",     int'(bus.status_led), 0);
      check("rst_loss",    int'(bus.loss_count), 0);
      @(negedge clk10);
      rst = 1'b0;

`ifndef LOCK_SUP_STICKY_FAULT_EN
      // locked for 10 edges -> RUN on the 11th sampling edge; then a loss,
      // a full FAULT period, re-lock, a HOLD glitch and a final-HOLD-cycle drop.
      tbl[0]  = '{1'b1, 10, 2'd1, 1'b1, 0};
      tbl[1]  = '{1'b1,  1, 2'd2, 1'b0, 0};
      tbl[2]  = '{1'b0,  3, 2'd3, 1'b1, 1};
      tbl[3]  = '{1'b1, 15, 2'd3, 1'b1, 1};
      tbl[4]  = '{1'b1,  1, 2'd0, 1'b1, 1};
      tbl[5]  = '{1'b1,  1, 2'd1, 1'b1, 1};
      tbl[6]  = '{1'b1,  8, 2'd2, 1'b0, 1};
      tbl[7]  = '{1'b0,  3, 2'd3, 1'b1, 2};
      tbl[8]  = '{1'b1, 16, 2'd0, 1'b1, 2};
      tbl[9]  = '{1'b1,  4, 2'd1, 1'b1, 2};
      tbl[10] = '{1'b0,  1, 2'd1, 1'b1, 2};
      tbl[11] = '{1'b1,  2, 2'd0, 1'b1, 2};
      tbl[12] = '{1'b1,  1, 2'd1, 1'b1, 2};
      tbl[13] = '{1'b1,  7, 2'd1, 1'b1, 2};
      tbl[14] = '{1'b1,  1, 2'd2, 1'b0, 2};
      tbl[15] = '{1'b0,  3, 2'd3, 1'b1, 3};
      tbl[16] = '{1'b1, 16, 2'd0, 1'b1, 3};
      tbl[17] = '{1'b1,  6, 2'd1, 1'b1, 3};
      tbl[18] = '{1'b0,  1, 2'd1, 1'b1, 3};
      tbl[19] = '{1'b1,  2, 2'd0, 1'b1, 3};
      tbl[20] = '{1'b1, 10, 2'd2, 1'b0, 3};
      for (int i = 0; i < NV; i++) begin
         drive(tbl[i].lk, tbl[i].cyc);
         check($sformatf("vec%0d_state", i),   int'(bus.state),      int'(tbl[i].st));
         check($sformatf("vec%0d_rst_out", i), int'(bus.rst_out),    int'(tbl[i].ro));
         check($sformatf("vec%0d_loss", i),    int'(bus.loss_count), tbl[i].loss);
      end

      // Async reset in HOLD.
      async_reset_check("pre_hold");
      bus.locked = 1'b1;
      wait_state(2'd1, 10, "hold_reach");
      async_reset_check("in_hold");

      // Async reset in FAULT, after a counted loss.
      bus.locked = 1'b1;
      wait_state(2'd2, 30, "fault_run");
      drive(1'b0, 3);
      check("fault_state", int'(bus.state),      3);
      check("fault_loss",  int'(bus.loss_count), 1);
      async_reset_check("in_fault");

      // Saturation of loss_count over 2^LOSS_W + 3 losses.
      bus.locked = 1'b1;
      for (int k = 1; k <= LOSS_MAX + 4; k++) begin
         wait_state(2'd2, 60, "sat_run");
         drive(1'b0, 3);
         check("sat_loss", int'(bus.loss_count), (k > LOSS_MAX) ? LOSS_MAX : k);
         bus.locked = 1'b1;
      end
      check("sat_final", int'(bus.loss_count), 255);
      async_reset_check("post_sat");
`else
      // Terminal FAULT: one loss, then locked held high for over 1000 cycles.
      bus.locked = 1'b1;
      wait_state(2'd2, 30, "sticky_run");
      drive(1'b0, 3);
      check("sticky_enter", int'(bus.state), 3);
      drive(1'b1, 1100);
      check("sticky_state",   int'(bus.state),      3);
      check("sticky_rst_out", int'(bus.rst_out),    1);
      check("sticky_loss",    int'(bus.loss_count), 1);
      async_reset_check("sticky_clear");
      drive(1'b1, 3);
      check("sticky_relock", int'(bus.state), 1);
`endif

      // Randomised lock behaviour, checked cycle by cycle by the model.
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 24) == 0) begin
            async_reset_check("rnd_rst");
         end else if ($urandom_range(0, 3) == 0) begin
            drive(~bus.locked, 1);
         end else begin
            drive(($urandom_range(0, 3) != 0), $urandom_range(1, 25));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #(100 * 40000);
      n_errors++;
      $display("FAIL watchdog: simulation exceeded its cycle budget at t=%0t", $time);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/lock_supervisor.md
# lock_supervisor

Sits in the 10 MHz domain directly downstream of the clocking-wizard output and consumes its `locked` flag. Synchronises `locked` and holds the slow domain in reset until lock has been stable for a programmable number of cycles. Detects and counts lock losses and drives a status LED whose pattern encodes supervisor state. Its `rst_out` replaces the ad-hoc two-flop reset synchroniser in the 10 MHz domain.

## Interface
- `HOLD_CYCLES`, default 1000: consecutive synchronised-locked cycles required before reset release; legal range ≥ 2.
- `LOSS_W`, default 8: width of the lock-loss counter.
- `BLINK_BITS`, default 24: width of the free-running LED blink counter; legal range ≥ 5.
- `clk10` in, 1 bit: 10 MHz clock from the PLL; the only clock.
- `rst` in, 1 bit: reset, asynchronous, active-high (button).
- `locked` in, 1 bit: PLL lock flag, asynchronous to `clk10`.
- `rst_out` out, 1 bit: registered active-high reset for the 10 MHz domain.
- `status_led` out, 1 bit: state-encoded LED drive.
- `loss_count` out, `LOSS_W` bits: number of RUN→FAULT transitions, saturating.
- `state` out, 2 bits: current FSM state, for ILA debug.

## Operation
- `locked` passes through a two-flop synchroniser (both flops ASYNC_REG, reset to 0), producing `locked_s`.
- FSM states and encodings: WAIT_LOCK = 0, HOLD = 1, RUN = 2, FAULT = 3.
- WAIT_LOCK:
  - `rst_out` = 1.
  - On `locked_s` = 1, go to HOLD and clear `hold_cnt`.
- HOLD:
  - `rst_out` = 1 and `hold_cnt` increments each cycle.
  - If `locked_s` = 0, go to WAIT_LOCK. No loss is counted.
  - Else if `hold_cnt` == `HOLD_CYCLES`-1, go to RUN.
  - `hold_cnt` width is `$clog2(HOLD_CYCLES)`.
- RUN:
  - `rst_out` = 0.
  - On `locked_s` = 0, go to FAULT and increment `loss_count`. At all-ones it stays all-ones and does not wrap.
- FAULT:
  - `rst_out` = 1 and `fault_cnt` (4 bits, cleared on entry) increments.
  - When `fault_cnt` == 15, go to WAIT_LOCK, regardless of `locked_s`.
- `rst_out` is a flop updated on the same edge as `state`: `rst_out` = 1 in every state except RUN.
- `blink_cnt` is free-running and cleared only by `rst`.
- `status_led` is registered and depends on state:
  - WAIT_LOCK: 0.
  - HOLD: 1.
  - RUN: `blink_cnt[BLINK_BITS-1]` (slow).
  - FAULT: `blink_cnt[BLINK_BITS-5]` (16× faster).
- Reset values: `state` = WAIT_LOCK, `rst_out` = 1, `status_led` = 0, `loss_count` = 0, all counters and synchroniser flops = 0.

## Timing
- `locked` rising before edge n gives `locked_s` = 1 after edge n+1, and `state` = HOLD after edge n+2.
- `state` = RUN and `rst_out` = 0 after edge n+2+`HOLD_CYCLES`.
- `locked` falling in RUN before edge m gives `state` = FAULT and `rst_out` = 1 after edge m+2. `loss_count` updates on the same edge.
- FAULT lasts exactly 16 cycles and then enters WAIT_LOCK.
- Any `locked_s` drop during HOLD, even on the final HOLD cycle, returns to WAIT_LOCK. The transition to RUN is not taken.
- `rst` asserted mid-operation forces all reset values immediately (asynchronously). Deassertion takes effect on the next `clk10` edge. `loss_count` is lost.
- `locked` glitches shorter than one `clk10` period may be missed. That is acceptable.

## Configuration
- Macro: `LOCK_SUP_STICKY_FAULT_EN`.
- Defined: FAULT is terminal. The FSM stays in FAULT with `rst_out` = 1 and fast blink until `rst`. `fault_cnt` is not implemented.
- Undefined: FAULT auto-recovers to WAIT_LOCK after 16 cycles, as described above.

## Test plan
All scenarios use `HOLD_CYCLES` = 8.
- Reset then `locked` = 1 constant: `rst_out` falls exactly 10 cycles after `locked` is first sampled, `state` = 2, `loss_count` = 0.
- `locked` high for 5 cycles, low for 1, then high: FSM returns to WAIT_LOCK, and `rst_out` falls 10 cycles after the second rise. `loss_count` stays 0.
- In RUN, drop `locked` for 3 cycles: `rst_out` = 1 two cycles later and `loss_count` = 1. FAULT lasts 16 cycles, then WAIT_LOCK, then HOLD, then RUN again.
- Force 2^`LOSS_W`+3 lock losses: `loss_count` saturates at 255 for `LOSS_W` = 8.
- Assert `rst` in HOLD and in FAULT: outputs take their reset values immediately, without waiting for a clock edge.
- With `LOCK_SUP_STICKY_FAULT_EN` defined: after one loss, `state` remains 3 for more than 1000 cycles with `locked` = 1, and clears only on `rst`.
